// File: rtl/proc_pkg.sv
// Shared constants for the 16-bit WISC-style core: opcodes, func codes,
// instruction field positions, reset PC and small datapath helper functions.
package proc_pkg;

   localparam logic [4:0] OP_HALT  = 5'b00000;
   localparam logic [4:0] OP_NOP   = 5'b00001;
   localparam logic [4:0] OP_J     = 5'b00100;
   localparam logic [4:0] OP_JR    = 5'b00101;
   localparam logic [4:0] OP_JAL   = 5'b00110;
   localparam logic [4:0] OP_JALR  = 5'b00111;
   localparam logic [4:0] OP_ADDI  = 5'b01000;
   localparam logic [4:0] OP_SUBI  = 5'b01001;
   localparam logic [4:0] OP_XORI  = 5'b01010;
   localparam logic [4:0] OP_ANDNI = 5'b01011;
   localparam logic [4:0] OP_BEQZ  = 5'b01100;
   localparam logic [4:0] OP_BNEZ  = 5'b01101;
   localparam logic [4:0] OP_BLTZ  = 5'b01110;
   localparam logic [4:0] OP_BGEZ  = 5'b01111;
   localparam logic [4:0] OP_SLBI  = 5'b10010;
   localparam logic [4:0] OP_ROLI  = 5'b10100;
   localparam logic [4:0] OP_SLLI  = 5'b10101;
   localparam logic [4:0] OP_RORI  = 5'b10110;
   localparam logic [4:0] OP_SRLI  = 5'b10111;
   localparam logic [4:0] OP_LBI   = 5'b11000;
   localparam logic [4:0] OP_BTR   = 5'b11001;
   localparam logic [4:0] OP_SHIFT = 5'b11010;
   localparam logic [4:0] OP_ARITH = 5'b11011;
   localparam logic [4:0] OP_SEQ   = 5'b11100;
   localparam logic [4:0] OP_SLT   = 5'b11101;
   localparam logic [4:0] OP_SLE   = 5'b11110;
   localparam logic [4:0] OP_SCO   = 5'b11111;

   localparam logic [1:0] FN_ADD  = 2'b00;
   localparam logic [1:0] FN_SUB  = 2'b01;
   localparam logic [1:0] FN_XOR  = 2'b10;
   localparam logic [1:0] FN_ANDN = 2'b11;
   localparam logic [1:0] FN_ROL  = 2'b00;
   localparam logic [1:0] FN_SLL  = 2'b01;
   localparam logic [1:0] FN_ROR  = 2'b10;
   localparam logic [1:0] FN_SRL  = 2'b11;

   localparam int OP_MSB = 15;
   localparam int OP_LSB = 11;
   localparam int RS_MSB = 10;
   localparam int RS_LSB = 8;
   localparam int RT_MSB = 7;
   localparam int RT_LSB = 5;
   localparam int RD_MSB = 4;
   localparam int RD_LSB = 2;

   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam logic [2:0]  LINK_REG = 3'd7;

   typedef struct packed {
      logic        en;
      logic [2:0]  addr;
      logic [15:0] data;
   } wb_t;

   function automatic logic [15:0] rotl16(input logic [15:0] a, input logic [3:0] n);
      logic [31:0] t;
      t = {a, a} << n;
      return t[31:16];
   endfunction

   function automatic logic [15:0] rotr16(input logic [15:0] a, input logic [3:0] n);
      logic [31:0] t;
      t = {a, a} >> n;
      return t[15:0];
   endfunction

   function automatic logic [15:0] bitrev16(input logic [15:0] a);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) begin
         r[i] = a[15-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/regfile.sv
// 8 x 16-bit register file: two combinational read ports, one write port
// committed on the rising edge, asynchronous active-low clear to zero.
module regfile
   import proc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  raddr1,
   input  logic [2:0]  raddr2,
   output logic [15:0] rdata1,
   output logic [15:0] rdata2,
   input  logic        we,
   input  logic [2:0]  waddr,
   input  logic [15:0] wdata
);

   logic [15:0] regs_q [8];
   logic [15:0] regs_d [8];

   // Next-state of the array: only the addressed entry changes.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         if (we && (waddr == 3'(i))) begin
            regs_d[i] = wdata;
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   // Register storage with async clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign rdata1 = regs_q[raddr1];
   assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/proc_hier_top.sv
// Single-cycle 16-bit WISC-style core with architectural trace port.
// Optional macro CYCLE_COUNT_EN adds the 32-bit cycle counter.
module proc_hier_top
   import proc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   output logic [15:0] pc,
   output logic [15:0] inst,
   output logic        reg_write,
   output logic [2:0]  write_reg,
   output logic [15:0] write_data,
   output logic        halt,
   output logic [31:0] cycle_count
);

   logic [15:0] pc_q, pc_d;
   logic        halt_q, halt_d;
   logic [15:0] rs_val, rt_val;
   logic        is_halt;
   wb_t         wb;

   logic [4:0]  op;
   logic [2:0]  rs_f, rt_f, rd_f;
   logic [1:0]  fn;
   logic [15:0] sext5, zext5, sext8, zext8, sext11, pc_plus2;
   logic [16:0] sum17;

   assign op      = imem_data[OP_MSB:OP_LSB];
   assign rs_f    = imem_data[RS_MSB:RS_LSB];
   assign rt_f    = imem_data[RT_MSB:RT_LSB];
   assign rd_f    = imem_data[RD_MSB:RD_LSB];
   assign fn      = imem_data[1:0];
   assign sext5   = {{11{imem_data[4]}}, imem_data[4:0]};
   assign zext5   = {11'd0, imem_data[4:0]};
   assign sext8   = {{8{imem_data[7]}}, imem_data[7:0]};
   assign zext8   = {8'd0, imem_data[7:0]};
   assign sext11  = {{5{imem_data[10]}}, imem_data[10:0]};
   assign pc_plus2 = pc_q + 16'd2;
   assign sum17   = {1'b0, rs_val} + {1'b0, rt_val};

   regfile u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr1 (rs_f),
      .raddr2 (rt_f),
      .rdata1 (rs_val),
      .rdata2 (rt_val),
      .we     (wb.en),
      .waddr  (wb.addr),
      .wdata  (wb.data)
   );

   // Decode/execute: next PC and the register write for this instruction.
   always_comb begin
      pc_d    = pc_plus2;
      wb      = '{en: 1'b0, addr: rd_f, data: 16'h0000};
      is_halt = 1'b0;
      if (halt_q) begin
         pc_d = pc_q;
      end else begin
         case (op)
            OP_HALT:  begin is_halt = 1'b1; pc_d = pc_q; end
            OP_ADDI:  wb = '{1'b1, rt_f, rs_val + sext5};
            OP_SUBI:  wb = '{1'b1, rt_f, sext5 - rs_val};
            OP_XORI:  wb = '{1'b1, rt_f, rs_val ^ zext5};
            OP_ANDNI: wb = '{1'b1, rt_f, rs_val & ~zext5};
            OP_ROLI:  wb = '{1'b1, rt_f, rotl16(rs_val, imem_data[3:0])};
            OP_SLLI:  wb = '{1'b1, rt_f, rs_val << imem_data[3:0]};
            OP_RORI:  wb = '{1'b1, rt_f, rotr16(rs_val, imem_data[3:0])};
            OP_SRLI:  wb = '{1'b1, rt_f, rs_val >> imem_data[3:0]};
            OP_LBI:   wb = '{1'b1, rs_f, sext8};
            OP_SLBI:  wb = '{1'b1, rs_f, (rs_val << 8) | zext8};
            OP_BTR:   wb = '{1'b1, rd_f, bitrev16(rs_val)};
            OP_ARITH: begin
               case (fn)
                  FN_ADD:  wb = '{1'b1, rd_f, rs_val + rt_val};
                  FN_SUB:  wb = '{1'b1, rd_f, rt_val - rs_val};
                  FN_XOR:  wb = '{1'b1, rd_f, rs_val ^ rt_val};
                  default: wb = '{1'b1, rd_f, rs_val & ~rt_val};
               endcase
            end
            OP_SHIFT: begin
               case (fn)
                  FN_ROL:  wb = '{1'b1, rd_f, rotl16(rs_val, rt_val[3:0])};
                  FN_SLL:  wb = '{1'b1, rd_f, rs_val << rt_val[3:0]};
                  FN_ROR:  wb = '{1'b1, rd_f, rotr16(rs_val, rt_val[3:0])};
                  default: wb = '{1'b1, rd_f, rs_val >> rt_val[3:0]};
               endcase
            end
            OP_SEQ:   wb = '{1'b1, rd_f, {15'd0, rs_val == rt_val}};
            OP_SLT:   wb = '{1'b1, rd_f, {15'd0, $signed(rs_val) < $signed(rt_val)}};
            OP_SLE:   wb = '{1'b1, rd_f, {15'd0, $signed(rs_val) <= $signed(rt_val)}};
            OP_SCO:   wb = '{1'b1, rd_f, {15'd0, sum17[16]}};
            OP_BEQZ:  if (rs_val == 16'h0000) pc_d = pc_plus2 + sext8; else pc_d = pc_plus2;
            OP_BNEZ:  if (rs_val != 16'h0000) pc_d = pc_plus2 + sext8; else pc_d = pc_plus2;
            OP_BLTZ:  if (rs_val[15])         pc_d = pc_plus2 + sext8; else pc_d = pc_plus2;
            OP_BGEZ:  if (!rs_val[15])        pc_d = pc_plus2 + sext8; else pc_d = pc_plus2;
            OP_J:     pc_d = pc_plus2 + sext11;
            OP_JR:    pc_d = rs_val + sext8;
            // Link uses PC+2; Rs was read combinationally before the R7 write commits.
            OP_JAL:   begin pc_d = pc_plus2 + sext11; wb = '{1'b1, LINK_REG, pc_plus2}; end
            OP_JALR:  begin pc_d = rs_val + sext8;    wb = '{1'b1, LINK_REG, pc_plus2}; end
            default:  pc_d = pc_plus2;
         endcase
      end
      halt_d = halt_q | is_halt;
   end

   // PC and halt latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         halt_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         halt_q <= halt_d;
      end
   end

`ifdef CYCLE_COUNT_EN
   logic [31:0] cyc_q, cyc_d;

   assign cyc_d = cyc_q + 32'd1;

   // Free-running cycle counter, wraps at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= 32'd0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   assign cycle_count = cyc_q;
`else
   assign cycle_count = 32'd0;
`endif

   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign inst       = imem_data;
   assign reg_write  = rst_n & wb.en;
   assign write_reg  = wb.addr;
   assign write_data = wb.data;
   assign halt       = rst_n & (halt_q | is_halt);

endmodule

// File: tb/tb_proc_hier_top.sv
// Scoreboard bench for proc_hier_top: expected trace records are queued
// with each program load and compared one per executed cycle.
module tb_proc_hier_top;

   logic        clk;
   logic        rst_n;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic [15:0] pc;
   logic [15:0] inst;
   logic        reg_write;
   logic [2:0]  write_reg;
   logic [15:0] write_data;
   logic        halt;
   logic [31:0] cycle_count;

   logic [15:0] mem [0:127];

   typedef struct {
      logic [15:0] pc;
      logic [15:0] inst;
      logic        rw;
      logic [2:0]  wr;
      logic [15:0] wd;
      logic        hlt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   proc_hier_top u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .pc          (pc),
      .inst        (inst),
      .reg_write   (reg_write),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .halt        (halt),
      .cycle_count (cycle_count)
   );

   assign imem_data = mem[imem_addr[7:1]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] p, input logic [15:0] i, input logic rw,
                       input logic [2:0] wr, input logic [15:0] wd, input logic h);
      exp_t e;
      e.pc = p; e.inst = i; e.rw = rw; e.wr = wr; e.wd = wd; e.hlt = h;
      sb.push_back(e);
   endtask

   task automatic put(input logic [15:0] addr, input logic [15:0] word);
      mem[addr[7:1]] = word;
   endtask

   function automatic logic [31:0] exp_cyc(input int k);
`ifdef CYCLE_COUNT_EN
      return 32'(k);
`else
      return 32'd0 + 32'(k * 0);
`endif
   endfunction

   // Pops one record per cycle; called right after reset release on a negedge.
   task automatic drain(input string ph);
      int k;
      exp_t e;
      k = 0;
      while (sb.size() > 0) begin
         #2;
         e = sb.pop_front();
         check_eq($sformatf("%s pc[%0d]", ph, k), {16'd0, pc}, {16'd0, e.pc});
         check_eq($sformatf("%s inst[%0d]", ph, k), {16'd0, inst}, {16'd0, e.inst});
         check_eq($sformatf("%s rw[%0d]", ph, k), {31'd0, reg_write}, {31'd0, e.rw});
         check_eq($sformatf("%s halt[%0d]", ph, k), {31'd0, halt}, {31'd0, e.hlt});
         if (e.rw) begin
            check_eq($sformatf("%s wreg[%0d]", ph, k), {29'd0, write_reg}, {29'd0, e.wr});
            check_eq($sformatf("%s wdata[%0d]", ph, k), {16'd0, write_data}, {16'd0, e.wd});
         end
         check_eq($sformatf("%s cyc[%0d]", ph, k), cycle_count, exp_cyc(k));
         k++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = 16'h0800;

      // Program A: arithmetic, shifts/rotates, branches, jumps, halt.
      put(16'h0000, 16'hC1FD); push(16'h0000, 16'hC1FD, 1'b1, 3'd1, 16'hFFFD, 1'b0);
      put(16'h0002, 16'hC105); push(16'h0002, 16'hC105, 1'b1, 3'd1, 16'h0005, 1'b0);
      put(16'h0004, 16'hC203); push(16'h0004, 16'hC203, 1'b1, 3'd2, 16'h0003, 1'b0);
      put(16'h0006, 16'hD94C); push(16'h0006, 16'hD94C, 1'b1, 3'd3, 16'h0008, 1'b0);
      put(16'h0008, 16'hD951); push(16'h0008, 16'hD951, 1'b1, 3'd4, 16'hFFFE, 1'b0);
      put(16'h000A, 16'h9134); push(16'h000A, 16'h9134, 1'b1, 3'd1, 16'h0534, 1'b0);
      put(16'h000C, 16'h44BF); push(16'h000C, 16'h44BF, 1'b1, 3'd5, 16'hFFFD, 1'b0);
      put(16'h000E, 16'h2000); push(16'h000E, 16'h2000, 1'b0, 3'd0, 16'h0000, 1'b0);
      put(16'h0010, 16'h6004); push(16'h0010, 16'h6004, 1'b0, 3'd0, 16'h0000, 1'b0);
      put(16'h0012, 16'hC17F);
      put(16'h0014, 16'hC17F);
      put(16'h0016, 16'h6804); push(16'h0016, 16'h6804, 1'b0, 3'd0, 16'h0000, 1'b0);
      put(16'h0018, 16'hEC58); push(16'h0018, 16'hEC58, 1'b1, 3'd6, 16'h0001, 1'b0);
      put(16'h001A, 16'hA1C4); push(16'h001A, 16'hA1C4, 1'b1, 3'd6, 16'h5340, 1'b0);
      put(16'h001C, 16'hB1C4); push(16'h001C, 16'hB1C4, 1'b1, 3'd6, 16'h4053, 1'b0);
      put(16'h001E, 16'hCA18); push(16'h001E, 16'hCA18, 1'b1, 3'd6, 16'hC000, 1'b0);
      put(16'h0020, 16'h3010); push(16'h0020, 16'h3010, 1'b1, 3'd7, 16'h0022, 1'b0);
      put(16'h0032, 16'h4AA2); push(16'h0032, 16'h4AA2, 1'b1, 3'd5, 16'hFFFF, 1'b0);
      put(16'h0034, 16'h87FF); push(16'h0034, 16'h87FF, 1'b0, 3'd0, 16'h0000, 1'b0);
      put(16'h0036, 16'h2F16); push(16'h0036, 16'h2F16, 1'b0, 3'd0, 16'h0000, 1'b0);
      put(16'h0038, 16'h0000);
      for (int i = 0; i < 4; i++) push(16'h0038, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1);

      @(negedge clk);
      #1;
      check_eq("rst pc", {16'd0, pc}, 32'd0);
      check_eq("rst rw", {31'd0, reg_write}, 32'd0);
      check_eq("rst halt", {31'd0, halt}, 32'd0);
      check_eq("rst cyc", cycle_count, 32'd0);
      @(negedge clk);
      check_eq("rst hold pc", {16'd0, pc}, 32'd0);
      rst_n = 1'b1;
      drain("A");

      // Asynchronous reset while halted, checked before any clock edge.
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("arst pc", {16'd0, pc}, 32'd0);
      check_eq("arst addr", {16'd0, imem_addr}, 32'd0);
      check_eq("arst cyc", cycle_count, 32'd0);
      check_eq("arst rw", {31'd0, reg_write}, 32'd0);
      check_eq("arst halt", {31'd0, halt}, 32'd0);

      // Program B: registers cleared by reset, PC wrap 0xFFFE -> 0x0000.
      for (int i = 0; i < 128; i++) mem[i] = 16'h0800;
      put(16'h0000, 16'h4361);
      put(16'h0002, 16'h28FE);
      put(16'hFFFE, 16'h4361);
      push(16'h0000, 16'h4361, 1'b1, 3'd3, 16'h0001, 1'b0);
      push(16'h0002, 16'h28FE, 1'b0, 3'd0, 16'h0000, 1'b0);
      push(16'hFFFE, 16'h4361, 1'b1, 3'd3, 16'h0002, 1'b0);
      push(16'h0000, 16'h4361, 1'b1, 3'd3, 16'h0003, 1'b0);
      push(16'h0002, 16'h28FE, 1'b0, 3'd0, 16'h0000, 1'b0);
      push(16'hFFFE, 16'h4361, 1'b1, 3'd3, 16'h0004, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drain("B");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
